bcd_countdown: RTL
==================

BCD_COUNTDOWN -- requirements
Module: bcd_countdown

Interface
REQ-001 Parameter INIT_MIN, default 10, preset minutes, 0..99, loaded on reset and on load.
REQ-002 Parameter INIT_SEC, default 0, preset seconds, 0..59.
REQ-003 Parameter BONUS_SEC, default 0, per-move increment in seconds, 0..59.
REQ-004 Port clkIn  input  1  system clock; all state changes on its rising edge.
REQ-005 Port reset  input  1  asynchronous, active-high reset.
REQ-006 Port tick  input  1  one-cycle 1 Hz strobe, synchronous to clkIn, from the frequency divider.
REQ-007 Port enable  input  1  level, high while this player's clock runs.
REQ-008 Port load  input  1  synchronous strobe that reloads the preset and returns to IDLE.
REQ-009 Port bonus  input  1  one-cycle strobe that adds BONUS_SEC to the remaining time.
REQ-010 Port minTens, minUnits, secTens, secUnits  output  4 each  registered BCD digits of the remaining time.
REQ-011 Port running  output  1  high while state is RUN.
REQ-012 Port expired  output  1  high while state is EXPIRED.
REQ-013 Port lowTime  output  1  high when minTens and minUnits are both 0 and expired is low.

Function
REQ-014 The block SHALL implement four states: IDLE, RUN, PAUSE, EXPIRED.
REQ-015 Transitions SHALL be: IDLE -> RUN on enable=1; RUN -> PAUSE on enable=0; PAUSE -> RUN on enable=1; RUN -> EXPIRED when the count reaches 00:00; EXPIRED holds until load or reset.
REQ-016 load=1 in any state SHALL, on the next edge, set the digits to INIT_MIN:INIT_SEC and the state to IDLE, overriding tick, bonus and enable.
REQ-017 A tick SHALL decrement the count by one second only when the state is already RUN; a tick in the cycle of the IDLE/PAUSE -> RUN transition is ignored.
REQ-018 Decrement SHALL be BCD: secUnits 0 -> 9 with borrow; secTens 0 -> 5 with borrow; minUnits 0 -> 9 with borrow into minTens.
REQ-019 A decrement from 00:01 SHALL give 00:00 and enter EXPIRED on the same edge, unless a bonus with BONUS_SEC>0 occurs in the same cycle.
REQ-020 A bonus SHALL be accepted only in RUN or PAUSE; it is ignored in IDLE and EXPIRED.
REQ-021 A bonus SHALL add BONUS_SEC with BCD carry (seconds wrap 59 -> 00 with carry into minutes) and saturate at 99:59.
REQ-022 For a simultaneous tick and bonus in RUN, the result SHALL be (count - 1 + BONUS_SEC), saturated at 99:59, and EXPIRED is entered only if that result is 00:00.
REQ-023 A tick while enable=0 SHALL have no effect; the digits hold in IDLE, PAUSE and EXPIRED.
REQ-024 The output latency SHALL be one clkIn cycle from the sampled strobe to the updated digits.
REQ-025 If INIT_MIN:INIT_SEC is 00:00, enable SHALL move IDLE directly to EXPIRED.

Reset
REQ-026 While reset=1, asynchronously: digits = INIT_MIN:INIT_SEC, state = IDLE, running = 0, expired = 0.
REQ-027 A reset asserted mid-count SHALL discard the count; operation resumes on the first edge after deassertion.
REQ-028 Reset SHALL take priority over load, and load over all other inputs.

Verification
REQ-029 Reset, enable=1, 3 ticks (INIT 10:00) -> digits 09:57, running = 1.
REQ-030 Count at 01:00, one tick -> 00:59 and lowTime = 1; at 00:01, one tick -> 00:00, expired = 1, running = 0; further ticks leave 00:00.
REQ-031 BONUS_SEC = 5, count at 00:58 in PAUSE, bonus -> 01:03; count at 99:57, bonus -> 99:59.
REQ-032 BONUS_SEC = 5, RUN at 00:01, tick and bonus in the same cycle -> 00:05, expired = 0.
REQ-033 RUN at 07:30, enable = 0 plus 4 ticks -> 07:30 in PAUSE; load together with a tick -> 10:00 in IDLE.
REQ-034 Reset pulse asserted between clock edges while at 03:12 -> outputs become 10:00 and IDLE immediately, before the next edge.

Source files
------------

// File: rtl/bcd_countdown.sv
// Chess-clock style BCD countdown for one player: MM:SS digits with run/pause,
// per-move bonus increment (saturating at 99:59) and expiry detection.
module bcd_countdown #(
    parameter int INIT_MIN  = 10,
    parameter int INIT_SEC  = 0,
    parameter int BONUS_SEC = 0
) (
    input  logic       clkIn,
    input  logic       reset,
    input  logic       tick,
    input  logic       enable,
    input  logic       load,
    input  logic       bonus,
    output logic [3:0] minTens,
    output logic [3:0] minUnits,
    output logic [3:0] secTens,
    output logic [3:0] secUnits,
    output logic       running,
    output logic       expired,
    output logic       lowTime
);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, EXPIRED} stateType;

    localparam logic [15:0] INIT_COUNT = {4'(INIT_MIN / 10), 4'(INIT_MIN % 10),
                                          4'(INIT_SEC / 10), 4'(INIT_SEC % 10)};
    localparam logic [4:0]  BONUS_TENS  = 5'(BONUS_SEC / 10);
    localparam logic [4:0]  BONUS_UNITS = 5'(BONUS_SEC % 10);

    stateType    state, nextState;
    logic [15:0] count, nextCount;

    // One-second BCD decrement with borrow through all four digits
    function automatic logic [15:0] bcdDec(input logic [15:0] t);
        logic [3:0] mt, mu, st, su;
        {mt, mu, st, su} = t;
        if (su != 4'd0) begin
            su = su - 4'd1;
        end else begin
            su = 4'd9;
            if (st != 4'd0) begin
                st = st - 4'd1;
            end else begin
                st = 4'd5;
                if (mu != 4'd0) begin
                    mu = mu - 4'd1;
                end else begin
                    mu = 4'd9;
                    mt = mt - 4'd1;
                end
            end
        end
        return {mt, mu, st, su};
    endfunction

    // Adds the bonus with carry from seconds into minutes, clamping at 99:59
    function automatic logic [15:0] bcdAddBonus(input logic [15:0] t);
        logic [3:0] mt, mu, st, su;
        logic [4:0] u, tn;
        logic       carry;
        {mt, mu, st, su} = t;
        u = {1'b0, su} + BONUS_UNITS;
        carry = (u >= 5'd10);
        if (carry) u = u - 5'd10;
        tn = {1'b0, st} + BONUS_TENS + {4'd0, carry};
        carry = (tn >= 5'd6);
        if (carry) tn = tn - 5'd6;
        su = u[3:0];
        st = tn[3:0];
        if (carry) begin
            if (mu != 4'd9) begin
                mu = mu + 4'd1;
            end else if (mt != 4'd9) begin
                mu = 4'd0;
                mt = mt + 4'd1;
            end else begin
                st = 4'd5;
                su = 4'd9;
            end
        end
        return {mt, mu, st, su};
    endfunction

    always_ff @(posedge clkIn or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            count <= INIT_COUNT;
        end else begin
            state <= nextState;
            count <= nextCount;
        end
    end

    // A tick only counts when already running and enable is still high
    always_comb begin
        logic [15:0] work;
        nextState = state;
        nextCount = count;
        work      = count;
        case (state)
            IDLE: begin
                if (enable) nextState = (count == 16'h0000) ? EXPIRED : RUN;
            end
            RUN: begin
                if (enable && tick) work = bcdDec(work);
                if (bonus) work = bcdAddBonus(work);
                nextCount = work;
                if (!enable) nextState = PAUSE;
                else if (work == 16'h0000) nextState = EXPIRED;
            end
            PAUSE: begin
                if (bonus) nextCount = bcdAddBonus(count);
                if (enable) nextState = RUN;
            end
            default: begin
                nextState = state;
            end
        endcase
        if (load) begin
            nextState = IDLE;
            nextCount = INIT_COUNT;
        end
    end

    assign {minTens, minUnits, secTens, secUnits} = count;
    assign running = (state == RUN);
    assign expired = (state == EXPIRED);
    assign lowTime = (minTens == 4'd0) && (minUnits == 4'd0) && !expired;

endmodule
